gen_pair_collector: RTL

Consumer end of the generator output stream. Launches a generator module, captures every yielded `(_out0, _out1)` pair into an internal FIFO, and re-presents the pairs downstream on a ready/valid interface. It reports completion once the generator has finished and every captured pair has been drained. It sits between a generated generator block and any consumer that cannot accept one pair per cycle.

---
 rtl/gen_pkg.sv | 20 ++
 rtl/pair_fifo.sv | 58 +++++
 rtl/gen_pair_collector.sv | 115 +++++++++++
 3 files changed

// File: rtl/gen_pkg.sv
// Shared types for the generator pair collector.
// Build option: GEN_COLLECTOR_COUNT_EN adds the _count port.
package gen_pkg;

   localparam int GEN_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LAUNCH  = 3'd1,
      COLLECT = 3'd2,
      DRAIN   = 3'd3,
      DONE    = 3'd4
   } state_t;

   typedef struct packed {
      logic signed [GEN_WIDTH-1:0] out0;
      logic signed [GEN_WIDTH-1:0] out1;
   } pair_t;

endpackage

// File: rtl/pair_fifo.sv
// Synchronous pair FIFO with extra-MSB pointers.
// A push into a full FIFO is taken only when a pop frees a slot.
module pair_fifo
   import gen_pkg::*;
#(
   parameter int  DEPTH = 8,
   parameter type T     = pair_t
) (
   input  logic clk,
   input  logic clr,
   input  logic push,
   input  logic pop,
   input  T     din,
   output T     head,
   output logic full,
   output logic empty,
   output logic accepted
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_q, wr_d;
   logic [AW:0] rd_q, rd_d;
   logic        do_pop;
   T            mem_q [DEPTH];

   // Status flags, accepted push/pop and next pointers.
   always_comb begin
      empty    = (wr_q == rd_q);
      full     = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
      do_pop   = pop && !empty;
      accepted = push && (!full || do_pop);
      wr_d     = wr_q;
      rd_d     = rd_q;
      if (clr) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (accepted) wr_d = wr_q + 1'b1;
         if (do_pop)   rd_d = rd_q + 1'b1;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk) begin
      wr_q <= wr_d;
      rd_q <= rd_d;
   end

   // Storage; written only on an accepted push.
   always_ff @(posedge clk) begin
      if (accepted && !clr) mem_q[wr_q[AW-1:0]] <= din;
   end

   assign head = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/gen_pair_collector.sv
// Launches a generator, buffers its pairs, replays them downstream.
// Build option: GEN_COLLECTOR_COUNT_EN adds the _count port.
module gen_pair_collector
   import gen_pkg::*;
#(
   parameter int WIDTH = GEN_WIDTH,
   parameter int DEPTH = 8
) (
   input  logic                    _clock,
   input  logic                    _reset,
   input  logic                    _start,
   output logic                    gen_start,
   input  logic signed [WIDTH-1:0] gen_out0,
   input  logic signed [WIDTH-1:0] gen_out1,
   input  logic                    gen_valid,
   input  logic                    gen_done,
   output logic signed [WIDTH-1:0] _out0,
   output logic signed [WIDTH-1:0] _out1,
   output logic                    _valid,
   input  logic                    _ready,
   output logic                    _done,
   output logic                    _overflow
`ifdef GEN_COLLECTOR_COUNT_EN
   ,
   output logic [31:0]             _count
`endif
);

   typedef struct packed {
      logic signed [WIDTH-1:0] out0;
      logic signed [WIDTH-1:0] out1;
   } lpair_t;

   state_t state_q, state_d;
   logic   ovf_q, ovf_d;
   logic   push_req, pop, full, empty, accepted;
   lpair_t din, head;

   assign din = '{out0: gen_out0, out1: gen_out1};

   pair_fifo #(
      .DEPTH (DEPTH),
      .T     (lpair_t)
   ) u_fifo (
      .clk      (_clock),
      .clr      (_reset),
      .push     (push_req),
      .pop      (pop),
      .din      (din),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .accepted (accepted)
   );

   // Run sequencing; _start is only honoured when idle or done.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (_start)   state_d = LAUNCH;
         LAUNCH:                state_d = COLLECT;
         COLLECT: if (gen_done) state_d = DRAIN;
         DRAIN:   if (empty)    state_d = DONE;
         DONE:    if (_start)   state_d = LAUNCH;
         default:               state_d = IDLE;
      endcase
   end

   // Capture, drain and sticky loss tracking.
   always_comb begin
      push_req = (state_q == COLLECT) && gen_valid;
      pop      = !empty && _ready;
      ovf_d    = ovf_q;
      if (state_q == LAUNCH)          ovf_d = 1'b0;
      else if (push_req && !accepted) ovf_d = 1'b1;
   end

   // State and overflow registers.
   always_ff @(posedge _clock) begin
      if (_reset) begin
         state_q <= IDLE;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef GEN_COLLECTOR_COUNT_EN
   logic [31:0] cnt_q, cnt_d;

   // Saturating count of accepted pairs for this run.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == LAUNCH)                cnt_d = '0;
      else if (accepted && cnt_q != '1)     cnt_d = cnt_q + 32'd1;
   end

   // Counter register.
   always_ff @(posedge _clock) begin
      if (_reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign _count = cnt_q;
`endif

   assign gen_start = (state_q == LAUNCH);
   assign _done     = (state_q == DONE);
   assign _overflow = ovf_q;
   assign _valid    = !empty;
   assign _out0     = empty ? '0 : head.out0;
   assign _out1     = empty ? '0 : head.out1;

endmodule
